// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared bitwise logic unit.
// The master side is the requesters plus the consumer; the slave side is the arbiter.
interface logic_unit_arbiter_if #(parameter int unsigned N = 4);
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_op;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_op;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [N-1:0] resp_data;
  logic         busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one N-bit NOT/AND/OR/XOR unit,
// with a single registered, id-tagged response slot.
module logic_unit_arbiter #(
  parameter int unsigned N = 4
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_arbiter_if.slave bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state;
  logic         last_grant;
  logic         id_q;
  logic [N-1:0] data_q;

  logic         slot_free;
  logic         grant;
  logic         acc0;
  logic         acc1;
  logic [N-1:0] result;

  function automatic logic [N-1:0] lu(input logic [1:0] op,
                                      input logic [N-1:0] a,
                                      input logic [N-1:0] b);
    case (op)
      2'b00:   lu = ~a;
      2'b01:   lu = a & b;
      2'b10:   lu = a | b;
      default: lu = a ^ b;
    endcase
  endfunction

  // rst_n gates ready directly so nothing is offered while reset is held.
  assign slot_free = rst_n & ((state == EMPTY) | bus.resp_ready);

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = ~last_grant;
    else if (bus.req1_valid)
      grant = 1'b1;
  end

  assign bus.req0_ready = slot_free & bus.req0_valid & ~grant;
  assign bus.req1_ready = slot_free & bus.req1_valid & grant;
  assign acc0 = bus.req0_valid & bus.req0_ready;
  assign acc1 = bus.req1_valid & bus.req1_ready;

  assign result = acc1 ? lu(bus.req1_op, bus.req1_a, bus.req1_b)
                       : lu(bus.req0_op, bus.req0_a, bus.req0_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      data_q     <= '0;
    end else if (acc0 || acc1) begin
      state      <= FULL;
      last_grant <= acc1;
      id_q       <= acc1;
      data_q     <= result;
    end else if (bus.resp_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.resp_valid = (state == FULL);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign bus.busy       = (state == FULL) & ~bus.resp_ready;

endmodule
